// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB stage: load-size encoding and the slot payload.
// Payload fields are sized for the widest legal configuration; the stage narrows them on use.
package memwb_pkg;

    localparam int unsigned MAX_DATA_W = 64;
    // Holds any register-file address width up to 8 bits.
    localparam int unsigned MAX_ADDR_W = 8;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [MAX_ADDR_W-1:0] wr_addr;
        logic [MAX_DATA_W-1:0] alu_result;
        logic [MAX_DATA_W-1:0] mem_data;
        ld_size_e              ld_size;
        logic                  ld_unsigned;
    } payload_t;

    // Register 0 is hard-wired, so writes to it never reach the register file.
    function automatic logic is_rf_write(input logic reg_write,
                                         input logic [MAX_ADDR_W-1:0] addr);
        return reg_write && (addr != '0);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Little-endian load lane extraction with sign/zero extension to DATA_W.
module load_extend
    import memwb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]             mem_data,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  ld_size_e                      size,
    input  logic                          is_unsigned,
    output logic [DATA_W-1:0]             data
);

    localparam int unsigned OFF_W = $clog2(DATA_W/8);
    localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);

    ld_size_e          eff_size;
    logic [OFF_W-1:0]  off_al;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    always_comb begin
        eff_size  = size;
        off_al    = '0;
        keep_mask = '1;
        sign_bit  = 1'b0;
        // A 32-bit datapath has no doubleword lane; D behaves as W.
        if ((DATA_W == 32) && (size == LD_D)) begin
            eff_size = LD_W;
        end

        case (eff_size)
            LD_B:    off_al = offset;
            LD_H:    off_al = offset & ~OFF_W'(1);
            LD_W:    off_al = offset & ~OFF_W'(3);
            default: off_al = '0;
        endcase

        lane = mem_data >> {off_al, 3'b000};

        case (eff_size)
            LD_B: begin
                keep_mask = MASK_B;
                sign_bit  = lane[7] & ~is_unsigned;
            end
            LD_H: begin
                keep_mask = MASK_H;
                sign_bit  = lane[15] & ~is_unsigned;
            end
            LD_W: begin
                keep_mask = MASK_W;
                sign_bit  = lane[31] & ~is_unsigned;
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase

        data = (lane & keep_mask) | ({DATA_W{sign_bit}} & ~keep_mask);
    end

endmodule

// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register with a two-slot skid buffer, flush, load extension
// and an EX-stage forwarding bypass.
module memwb_skid_reg
    import memwb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_wr_addr,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data
);

    localparam int unsigned OFF_W = $clog2(DATA_W/8);

    payload_t in_pl;
    payload_t out_q, out_d;
    payload_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     accept;
    logic     drain;

    always_comb begin
        in_pl             = '0;
        in_pl.mem_to_reg  = in_mem_to_reg;
        in_pl.reg_write   = in_reg_write;
        in_pl.wr_addr     = MAX_ADDR_W'(in_wr_addr);
        in_pl.alu_result  = MAX_DATA_W'(in_alu_result);
        in_pl.mem_data    = MAX_DATA_W'(in_mem_data);
        in_pl.ld_size     = ld_size_e'(in_ld_size);
        in_pl.ld_unsigned = in_ld_unsigned;
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || (drain && !skid_valid_q)) begin
            out_valid_d = accept;
            if (accept) begin
                out_d = in_pl;
            end
        end else if (drain) begin
            // SKID is full here, so in_ready was low and nothing was accepted.
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_mem;
    logic [DATA_W-1:0] ld_data;
    logic              rf_write;

    assign out_alu  = DATA_W'(out_q.alu_result);
    assign out_mem  = DATA_W'(out_q.mem_data);
    assign rf_write = is_rf_write(out_q.reg_write, out_q.wr_addr);

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .mem_data    (out_mem),
        .offset      (out_alu[OFF_W-1:0]),
        .size        (out_q.ld_size),
        .is_unsigned (out_q.ld_unsigned),
        .data        (ld_data)
    );

    assign out_valid = out_valid_q;
    assign wb_addr   = REG_ADDR_W'(out_q.wr_addr);
    assign wb_data   = out_q.mem_to_reg ? ld_data : out_alu;
    assign fwd_valid = out_valid_q && rf_write;
    assign wb_we     = fwd_valid && out_ready;
    assign fwd_addr  = wb_addr;
    assign fwd_data  = wb_data;

    // Upper payload bits are unused in narrower configurations.
    logic unused_payload_bits;
    assign unused_payload_bits = ^{out_q.wr_addr, out_q.alu_result, out_q.mem_data};

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed bench for memwb_skid_reg: table-driven handshake/extension vectors plus
// hand-written flush and asynchronous-reset sequences; a 64-bit instance covers LD_D.
module tb_memwb_skid_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        iv, irdy, m2r, rw, uns, fl, ov, ordy, we, fv;
    logic [4:0]  wa, waddr, faddr;
    logic [31:0] alu, mem, wdata, fdata;
    logic [1:0]  sz;

    // 64-bit instance
    logic        iv64, irdy64, m2r64, rw64, uns64, ov64, ordy64, we64, fv64;
    logic [4:0]  wa64, waddr64, faddr64;
    logic [63:0] alu64, mem64, wdata64, fdata64;
    logic [1:0]  sz64;

    memwb_skid_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (iv),
        .in_ready       (irdy),
        .in_mem_to_reg  (m2r),
        .in_reg_write   (rw),
        .in_wr_addr     (wa),
        .in_alu_result  (alu),
        .in_mem_data    (mem),
        .in_ld_size     (sz),
        .in_ld_unsigned (uns),
        .flush          (fl),
        .out_valid      (ov),
        .out_ready      (ordy),
        .wb_we          (we),
        .wb_addr        (waddr),
        .wb_data        (wdata),
        .fwd_valid      (fv),
        .fwd_addr       (faddr),
        .fwd_data       (fdata)
    );

    memwb_skid_reg #(.DATA_W(64), .REG_ADDR_W(5)) dut64 (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (iv64),
        .in_ready       (irdy64),
        .in_mem_to_reg  (m2r64),
        .in_reg_write   (rw64),
        .in_wr_addr     (wa64),
        .in_alu_result  (alu64),
        .in_mem_data    (mem64),
        .in_ld_size     (sz64),
        .in_ld_unsigned (uns64),
        .flush          (fl),
        .out_valid      (ov64),
        .out_ready      (ordy64),
        .wb_we          (we64),
        .wb_addr        (waddr64),
        .wb_data        (wdata64),
        .fwd_valid      (fv64),
        .fwd_addr       (faddr64),
        .fwd_data       (fdata64)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic r, input logic f,
                             input logic [4:0] a, input logic [31:0] d);
        iv = v; ordy = r; fl = f; m2r = 1'b0; rw = 1'b1; wa = a; alu = d;
        mem = 32'hDEAD_BEEF; sz = 2'd2; uns = 1'b0;
        #1;
    endtask

    // Inputs applied for one cycle; expected outputs are those seen before the edge.
    typedef struct {
        logic        iv, ordy, m2r, rw;
        logic [4:0]  wa;
        logic [31:0] alu, mem;
        logic [1:0]  sz;
        logic        uns;
        logic        e_irdy, e_ov, e_we, e_fv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic r, input logic mr, input logic w,
                                input logic [4:0] a, input logic [31:0] al, input logic [31:0] md,
                                input logic [1:0] s, input logic u,
                                input logic eir, input logic eov, input logic ewe, input logic efv,
                                input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t t;
        t.iv = v; t.ordy = r; t.m2r = mr; t.rw = w; t.wa = a; t.alu = al; t.mem = md;
        t.sz = s; t.uns = u; t.e_irdy = eir; t.e_ov = eov; t.e_we = ewe; t.e_fv = efv;
        t.e_wa = ewa; t.e_wd = ewd;
        return t;
    endfunction

    localparam logic [31:0] M = 32'h80FF_7F01;
    localparam logic [31:0] X = 32'hDEAD_BEEF;
    localparam logic [63:0] M64 = 64'h8877_6655_4433_2211;

    vec_t tv[23];

    initial begin
        rst_n = 1'b0;
        iv = 0; ordy = 0; m2r = 0; rw = 0; wa = '0; alu = '0; mem = '0; sz = '0; uns = 0; fl = 0;
        iv64 = 0; ordy64 = 0; m2r64 = 0; rw64 = 0; wa64 = '0; alu64 = '0; mem64 = '0;
        sz64 = '0; uns64 = 0;

        // ALU stream, back-pressure, load extension, register-0 writes
        tv[0]  = mk(1,1,0,1,  1,'h11,X,2,0, 1,0,0,0,  0,0);
        tv[1]  = mk(1,1,0,1,  2,'h22,X,2,0, 1,1,1,1,  1,'h11);
        tv[2]  = mk(1,1,0,1,  3,'h33,X,2,0, 1,1,1,1,  2,'h22);
        tv[3]  = mk(1,1,0,1,  4,'h44,X,2,0, 1,1,1,1,  3,'h33);
        tv[4]  = mk(0,1,0,1,  0,0,X,2,0,    1,1,1,1,  4,'h44);
        tv[5]  = mk(0,0,0,0,  0,0,X,2,0,    1,0,0,0,  0,0);
        tv[6]  = mk(1,0,0,1,  5,'h55,X,2,0, 1,0,0,0,  0,0);
        tv[7]  = mk(1,0,0,1,  6,'h66,X,2,0, 1,1,0,1,  5,'h55);
        tv[8]  = mk(1,0,0,1,  7,'h77,X,2,0, 0,1,0,1,  5,'h55);
        tv[9]  = mk(1,1,0,1,  7,'h77,X,2,0, 0,1,1,1,  5,'h55);
        tv[10] = mk(1,1,0,1,  7,'h77,X,2,0, 1,1,1,1,  6,'h66);
        tv[11] = mk(0,1,0,1,  0,0,X,2,0,    1,1,1,1,  7,'h77);
        tv[12] = mk(0,1,0,1,  0,0,X,2,0,    1,0,0,0,  0,0);
        tv[13] = mk(1,1,1,1,  8,1,M,0,0,    1,0,0,0,  0,0);
        tv[14] = mk(1,1,1,1,  9,3,M,0,0,    1,1,1,1,  8,'h7F);
        tv[15] = mk(1,1,1,1, 10,2,M,1,1,    1,1,1,1,  9,'hFFFF_FF80);
        tv[16] = mk(1,1,1,1, 11,0,M,2,0,    1,1,1,1, 10,'h80FF);
        tv[17] = mk(1,1,1,1, 12,3,M,1,0,    1,1,1,1, 11,M);
        tv[18] = mk(1,1,1,1, 13,2,M,3,0,    1,1,1,1, 12,'hFFFF_80FF);
        tv[19] = mk(1,1,0,1,  0,'h99,X,2,0, 1,1,1,1, 13,M);
        tv[20] = mk(0,0,0,1,  0,0,X,2,0,    1,1,0,0,  0,'h99);
        tv[21] = mk(0,1,0,1,  0,0,X,2,0,    1,1,0,0,  0,'h99);
        tv[22] = mk(0,1,0,0,  0,0,X,2,0,    1,0,0,0,  0,0);

        // Reset state
        #3;
        chk("rst in_ready", irdy, 1);
        chk("rst out_valid", ov, 0);
        chk("rst wb_we", we, 0);
        chk("rst fwd_valid", fv, 0);
        chk("rst wb_addr", waddr, 0);
        chk("rst wb_data", wdata, 0);
        chk("rst fwd_data", fdata, 0);
        chk("rst64 wb_data", wdata64, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 64-bit extraction
        iv64 = 1; ordy64 = 1; m2r64 = 1; rw64 = 1; wa64 = 1; alu64 = 0; sz64 = 2'd3;
        uns64 = 0; mem64 = M64;
        tick();
        wa64 = 2; alu64 = 4; sz64 = 2'd2; uns64 = 1;
        #1;
        chk("d64 LD_D", wdata64, M64);
        tick();
        wa64 = 3; alu64 = 4; sz64 = 2'd2; uns64 = 0;
        #1;
        chk("d64 LWU off4", wdata64, 64'h0000_0000_8877_6655);
        tick();
        iv64 = 0;
        #1;
        chk("d64 LW off4", wdata64, 64'hFFFF_FFFF_8877_6655);
        tick();

        for (int i = 0; i < 23; i++) begin
            iv = tv[i].iv; ordy = tv[i].ordy; m2r = tv[i].m2r; rw = tv[i].rw; wa = tv[i].wa;
            alu = tv[i].alu; mem = tv[i].mem; sz = tv[i].sz; uns = tv[i].uns; fl = 1'b0;
            #1;
            chk($sformatf("v%0d in_ready", i), irdy, tv[i].e_irdy);
            chk($sformatf("v%0d out_valid", i), ov, tv[i].e_ov);
            chk($sformatf("v%0d wb_we", i), we, tv[i].e_we);
            chk($sformatf("v%0d fwd_valid", i), fv, tv[i].e_fv);
            if (tv[i].e_ov) begin
                chk($sformatf("v%0d wb_addr", i), waddr, tv[i].e_wa);
                chk($sformatf("v%0d wb_data", i), wdata, tv[i].e_wd);
                chk($sformatf("v%0d fwd_addr", i), faddr, tv[i].e_wa);
                chk($sformatf("v%0d fwd_data", i), fdata, tv[i].e_wd);
            end
            tick();
        end

        // Flush with both slots full and a pending input
        drive_alu(1, 0, 0, 14, 'hA1);
        tick();
        drive_alu(1, 0, 0, 15, 'hB2);
        tick();
        drive_alu(1, 0, 1, 16, 'hC3);
        chk("flush full in_ready", irdy, 0);
        chk("flush full wb_we", we, 0);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("post flush out_valid", ov, 0);
        chk("post flush in_ready", irdy, 1);
        chk("post flush wb_we", we, 0);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("post flush2 wb_we", we, 0);
        tick();

        // Flush on an empty stage discards the accepted input
        drive_alu(1, 1, 1, 17, 'hD4);
        chk("flush empty in_ready", irdy, 1);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("flush discard out_valid", ov, 0);
        tick();

        // Flush together with out_ready: current entry still writes
        drive_alu(1, 1, 0, 18, 'hE5);
        tick();
        drive_alu(0, 1, 1, 0, 0);
        chk("flush+drain wb_we", we, 1);
        chk("flush+drain wb_addr", waddr, 18);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("flush+drain out_valid", ov, 0);
        tick();

        // Asynchronous reset mid-stall
        drive_alu(1, 0, 0, 19, 'hF6);
        tick();
        drive_alu(1, 0, 0, 20, 'h07);
        tick();
        drive_alu(0, 0, 0, 0, 0);
        chk("stall in_ready", irdy, 0);
        chk("stall out_valid", ov, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", ov, 0);
        chk("arst in_ready", irdy, 1);
        chk("arst fwd_valid", fv, 0);
        chk("arst wb_addr", waddr, 0);
        chk("arst wb_data", wdata, 0);
        chk("arst fwd_data", fdata, 0);
        tick();
        rst_n = 1'b1;
        drive_alu(1, 1, 0, 21, 'h21);
        chk("rel out_valid", ov, 0);
        chk("rel wb_we", we, 0);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("rel latency out_valid", ov, 1);
        chk("rel wb_we", we, 1);
        chk("rel wb_addr", waddr, 21);
        chk("rel wb_data", wdata, 'h21);
        tick();
        drive_alu(0, 1, 0, 0, 0);
        chk("rel drained out_valid", ov, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
